// File: rtl/rs_rr_arb_if.sv
// rs_rr_arb_if: requester fan-in and single output stream of the round-robin arbiter
interface rs_rr_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int PLD_WIDTH = 32
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]           s_vld;
  logic [NUM_REQ*PLD_WIDTH-1:0] s_pld;
  logic [NUM_REQ-1:0]           s_last;
  logic [NUM_REQ-1:0]           s_rdy;
  logic                         m_vld;
  logic [PLD_WIDTH-1:0]         m_pld;
  logic [ID_WIDTH-1:0]          m_id;
  logic                         m_last;
  logic                         m_rdy;
  modport slave (
    input  s_vld, s_pld, s_last, m_rdy,
    output s_rdy, m_vld, m_pld, m_id, m_last
  );
  modport master (
    output s_vld, s_pld, s_last, m_rdy,
    input  s_rdy, m_vld, m_pld, m_id, m_last
  );
endinterface

// File: rtl/rs_rr_arb.sv
// rs_rr_arb: round-robin fan-in into one registered output slice; RS_ARB_LOCK_EN holds grant for whole bursts
module rs_rr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int PLD_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  rs_rr_arb_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  localparam int SW = ID_WIDTH + 1;
  logic [ID_WIDTH-1:0] ptr, g, idx, nxt;
  logic [SW-1:0]       sum;
  logic                ld, hit, hs;
`ifdef RS_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} st_t;
  st_t                 st;
  logic [ID_WIDTH-1:0] lock_id;
`endif
  assign ld  = !bus.m_vld || bus.m_rdy;
  assign nxt = (g == ID_WIDTH'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  // scan downwards so the lowest offset from ptr wins
  always_comb begin
    g   = ptr;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      idx = (sum >= SW'(NUM_REQ)) ? ID_WIDTH'(sum - SW'(NUM_REQ)) : sum[ID_WIDTH-1:0];
      if (bus.s_vld[idx]) g = idx;
    end
    hit = |bus.s_vld;
`ifdef RS_ARB_LOCK_EN
    if (st == LOCKED) begin
      g   = lock_id;
      hit = bus.s_vld[lock_id];
    end
`endif
    hs = ld && hit && !rst;
    bus.s_rdy = '0;
    bus.s_rdy[g] = hs;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_vld  <= 1'b0;
      bus.m_pld  <= '0;
      bus.m_id   <= '0;
      bus.m_last <= 1'b0;
      ptr        <= '0;
`ifdef RS_ARB_LOCK_EN
      st         <= IDLE;
      lock_id    <= '0;
`endif
    end else if (ld) begin
      bus.m_vld <= hs;
      if (hs) begin
        bus.m_pld  <= bus.s_pld[g*PLD_WIDTH +: PLD_WIDTH];
        bus.m_id   <= g;
        bus.m_last <= bus.s_last[g];
`ifdef RS_ARB_LOCK_EN
        st      <= bus.s_last[g] ? IDLE : LOCKED;
        lock_id <= g;
        if (bus.s_last[g]) ptr <= nxt;
`else
        ptr <= nxt;
`endif
      end
    end
  end
endmodule
